gray_float_to_byte: RTL and testbench
=====================================

GRAY_FLOAT_TO_BYTE -- requirements
Module: gray_float_to_byte

Interface
REQ-001 Parameter: NUM_PIXELS, default 106233, pixels per frame (1..262143).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  32  IEEE-754 single-precision grayscale sample from the RGB-to-gray stage.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 out_pixel  output  8  unsigned 8-bit gray pixel.
REQ-008 out_valid  output  1  out_pixel valid.
REQ-009 out_ready  input  1  downstream accepts out_pixel.
REQ-010 pixel_count  output  18  pixels delivered in the current frame.
REQ-011 frame_done  output  1  one-cycle pulse on delivery of the last pixel of a frame.

Function
REQ-012 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-013 Three-stage pipeline S1 unpack, S2 align/shift, S3 round/saturate; each stage has its own valid bit.
REQ-014 Latency: 3 cycles from input transfer to out_valid when no stall occurs; throughput 1 pixel/cycle.
REQ-015 Stall: stall = out_valid && !out_ready; during a stall all stages and valid bits hold and in_ready = 0.
REQ-016 in_ready = !stall (combinational); bubbles propagate, so an empty stage never blocks.
REQ-017 out_pixel and out_valid are held stable while stalled.
REQ-018 Conversion: sign = bit31, exp = bits30:23, man = bits22:0.
REQ-019 NaN (exp = 255, man != 0), negative values (sign = 1, including -0), exp = 0 (zero and denormals) -> 0x00.
REQ-020 +Inf, or exp >= 135 (value >= 256.0) -> 0xFF.
REQ-021 exp < 126 (value < 0.5) -> 0x00.
REQ-022 126 <= exp <= 134: form 24-bit significand {1,man}, shift right by (150 - exp), and round half-up using the first discarded bit.
REQ-023 A rounded result of 256 saturates to 0xFF; no other result exceeds 255.
REQ-024 pixel_count increments by 1 on each output transfer.
REQ-025 On the output transfer where pixel_count == NUM_PIXELS-1: frame_done = 1 for exactly that cycle, and pixel_count wraps to 0 on the next edge.
REQ-026 frame_done is combinational: (out_valid && out_ready && pixel_count == NUM_PIXELS-1); it is never asserted during a stall.
REQ-027 A simultaneous input transfer and output transfer in the same cycle is legal; the pipeline advances by one stage.

Reset
REQ-028 When rst = 1 at a clock edge: all stage valid bits clear, out_valid = 0, out_pixel = 0x00, pixel_count = 0.
REQ-029 Reset mid-frame or mid-stall discards in-flight samples; no output transfer occurs in the reset cycle or in the following cycle.
REQ-030 in_ready = 1 in the first cycle after rst deasserts.
REQ-031 Stage data registers other than out_pixel need no reset.

Verification
REQ-032 Stream 0x42C80000, 0x42C90000, 0x3F000000, 0x437F0000 with out_ready = 1 -> out_pixel sequence 100, 101, 1, 255, first output 3 cycles after the first transfer, then one output per cycle.
REQ-033 Edge values 0x3EFFFFFF, 0xBF800000, 0x7FC00000, 0x00000001, 0x437F8000, 0x43800000, 0x7F800000 -> 0, 0, 0, 0, 255, 255, 255.
REQ-034 Hold out_ready = 0 for 5 cycles with a full pipeline -> in_ready = 0, out_pixel stable; no samples lost or duplicated after release (compare against a reference model).
REQ-035 NUM_PIXELS = 4; send 9 samples with random out_ready -> frame_done pulses on delivered pixels #4 and #8 only; pixel_count = 1 after pixel #9.
REQ-036 Assert rst for one cycle with 2 samples in flight and pixel_count = 2 -> no stale output; pixel_count = 0; the next sample emerges with 3-cycle latency.
REQ-037 Random in_valid/out_ready, 10k random floats in [-10, 300] plus specials -> outputs match the model bit-exactly and in order.

Source files
------------

// File: rtl/gray_float_to_byte_if.sv
// Stream bundle for gray_float_to_byte: float samples in, 8-bit pixels out,
// plus per-frame delivery status.
interface gray_float_to_byte_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] pixel_count;
  logic        frame_done;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_pixel, out_valid, pixel_count, frame_done
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_pixel, out_valid, pixel_count, frame_done
  );
endinterface

// File: rtl/gray_float_to_byte.sv
// Converts IEEE-754 single-precision gray samples to saturated 8-bit pixels
// through a 3-stage stallable pipeline, counting pixels per frame.
module gray_float_to_byte #(
  parameter int NUM_PIXELS = 106233
) (
  input  logic clk,
  input  logic rst,
  gray_float_to_byte_if.slave bus
);

  localparam logic [17:0] LAST_IDX = 18'(NUM_PIXELS - 1);

  logic        stall;
  logic        advance;
  logic        out_xfer;

  logic        s1_valid_reg;
  logic        s1_zero_reg;
  logic        s1_sat_reg;
  logic [7:0]  s1_exp_reg;
  logic [22:0] s1_man_reg;

  logic        s2_valid_reg;
  logic        s2_zero_reg;
  logic        s2_sat_reg;
  logic [7:0]  s2_int_reg;
  logic        s2_rnd_reg;

  logic        s3_valid_reg;
  logic [7:0]  out_pixel_reg;
  logic [17:0] pixel_count_reg;

  logic        in_sign;
  logic [7:0]  in_exp;
  logic [22:0] in_man;
  logic        s1_zero_next;
  logic        s1_sat_next;
  logic [7:0]  shift_amt;
  logic [8:0]  shifted;
  logic [8:0]  s3_sum;
  logic [7:0]  out_pixel_next;

  // Gating with rst guarantees no output transfer during the reset cycle.
  assign bus.out_valid   = s3_valid_reg && !rst;
  assign stall           = bus.out_valid && !bus.out_ready;
  assign advance         = !stall;
  assign bus.in_ready    = !stall;
  assign out_xfer        = bus.out_valid && bus.out_ready;
  assign bus.frame_done  = out_xfer && (pixel_count_reg == LAST_IDX);
  assign bus.out_pixel   = out_pixel_reg;
  assign bus.pixel_count = pixel_count_reg;

  assign in_sign = bus.in_data[31];
  assign in_exp  = bus.in_data[30:23];
  assign in_man  = bus.in_data[22:0];

  always_comb begin
    s1_zero_next = in_sign || (in_exp < 8'd126) || ((in_exp == 8'd255) && (in_man != 23'd0));
    s1_sat_next  = !s1_zero_next && (in_exp >= 8'd135);
  end

  // Shift one less than (150 - exp) so bit 0 is the first discarded bit.
  always_comb begin
    shift_amt = 8'd149 - s1_exp_reg;
    shifted   = 9'({1'b1, s1_man_reg} >> shift_amt);
  end

  always_comb begin
    s3_sum = {1'b0, s2_int_reg} + {8'd0, s2_rnd_reg};
    out_pixel_next = s3_sum[7:0];
    if (s2_zero_reg) begin
      out_pixel_next = 8'h00;
    end else if (s2_sat_reg || s3_sum[8]) begin
      out_pixel_next = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s2_valid_reg    <= 1'b0;
      s3_valid_reg    <= 1'b0;
      out_pixel_reg   <= 8'h00;
      pixel_count_reg <= 18'd0;
    end else begin
      if (advance) begin
        s1_valid_reg <= bus.in_valid;
        s2_valid_reg <= s1_valid_reg;
        s3_valid_reg <= s2_valid_reg;
        if (s2_valid_reg) begin
          out_pixel_reg <= out_pixel_next;
        end
      end
      if (out_xfer) begin
        pixel_count_reg <= (pixel_count_reg == LAST_IDX) ? 18'd0 : pixel_count_reg + 18'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_zero_reg <= s1_zero_next;
      s1_sat_reg  <= s1_sat_next;
      s1_exp_reg  <= in_exp;
      s1_man_reg  <= in_man;
      s2_zero_reg <= s1_zero_reg;
      s2_sat_reg  <= s1_sat_reg;
      s2_int_reg  <= shifted[8:1];
      s2_rnd_reg  <= shifted[0];
    end
  end

endmodule

// File: tb/tb_gray_float_to_byte.sv
// Self-checking bench for gray_float_to_byte: a queue scoreboard filled on
// input transfers and drained on output transfers, with scenario tasks.
module tb_gray_float_to_byte;

  localparam int NPIX = 4;

  logic clk;
  logic rst;
  gray_float_to_byte_if bus();

  gray_float_to_byte #(.NUM_PIXELS(NPIX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  int          mcnt = 0;

  // Values sampled by step() just before the active edge.
  logic        ot, ov, fd, efd, ir;
  logic [7:0]  op;
  logic [17:0] pc, epc;

  function automatic logic [7:0] model(input logic [31:0] f);
    int  e;
    real val;
    e = int'(f[30:23]);
    if (f[31]) return 8'h00;
    if (e == 255) return (f[22:0] == 23'd0) ? 8'hFF : 8'h00;
    if (e == 0) return 8'h00;
    val = (8388608.0 + real'(f[22:0])) * (2.0 ** real'(e - 150));
    val = $floor(val + 0.5);
    if (val >= 255.0) return 8'hFF;
    return 8'(int'(val));
  endfunction

  function automatic logic [31:0] gen_float();
    int          k;
    logic [7:0]  e;
    logic [22:0] m;
    k = $urandom_range(0, 19);
    if (k < 2) begin
      case ($urandom_range(0, 7))
        0: return 32'h7FC00000;
        1: return 32'h7F800000;
        2: return 32'hFF800000;
        3: return 32'h80000000;
        4: return 32'h00000000;
        5: return 32'h00000001;
        6: return 32'h437F8000;
        default: return 32'h3F000000;
      endcase
    end
    if (k < 4) begin
      e = 8'($urandom_range(120, 129));
      m = 23'($urandom);
      return {1'b1, e, m};
    end
    e = 8'($urandom_range(120, 135));
    m = 23'($urandom);
    if (e == 8'd135) m = 23'($urandom_range(0, 32'h15FFFF));
    return {1'b0, e, m};
  endfunction

  // Drive one cycle of stimulus, sample outputs, update the scoreboard model.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    ir  = bus.in_ready;
    ov  = bus.out_valid;
    ot  = bus.out_valid && r;
    op  = bus.out_pixel;
    fd  = bus.frame_done;
    pc  = bus.pixel_count;
    epc = 18'(mcnt);
    efd = ot && (mcnt == NPIX - 1);
    if (v && ir && !rst) exp_q.push_back(model(d));
    if (ot) mcnt = (mcnt == NPIX - 1) ? 0 : mcnt + 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++;
    if (bus.out_pixel !== 8'h00) begin n_fail++; $display("FAIL reset_out_pixel got=%h exp=00", bus.out_pixel); end
    n_tests++;
    if (bus.pixel_count !== 18'd0) begin n_fail++; $display("FAIL reset_pixel_count got=%0d exp=0", bus.pixel_count); end
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [31:0] w[4];
    logic [7:0]  ev[4];
    logic [7:0]  e;
    int          got;
    w  = '{32'h42C80000, 32'h42C90000, 32'h3F000000, 32'h437F0000};
    ev = '{8'd100, 8'd101, 8'd1, 8'd255};
    got = 0;
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      step(cyc < 4, (cyc < 4) ? w[cyc] : 32'h0, 1'b1);
      if (ot) begin
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        $display("[TB] directed #%0d cyc=%0d pix=%0d", got, cyc, op);
        if (got >= 4) begin
          n_fail++; $display("FAIL directed_extra got=%0d exp=none", op);
        end else if (op !== ev[got] || op !== e || cyc != 3 + got) begin
          n_fail++; $display("FAIL directed_pix%0d got=%0d@%0d exp=%0d@%0d", got, op, cyc, ev[got], 3 + got);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 4) begin n_fail++; $display("FAIL directed_count got=%0d exp=4", got); end
  endtask

  task automatic test_edges();
    logic [31:0] w[7];
    logic [7:0]  ev[7];
    logic [7:0]  e;
    int          got;
    w  = '{32'h3EFFFFFF, 32'hBF800000, 32'h7FC00000, 32'h00000001,
           32'h437F8000, 32'h43800000, 32'h7F800000};
    ev = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
    got = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      step(cyc < 7, (cyc < 7) ? w[cyc] : 32'h0, 1'b1);
      if (ot) begin
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        $display("[TB] edge #%0d pix=%0d", got, op);
        if (got >= 7) begin
          n_fail++; $display("FAIL edge_extra got=%0d exp=none", op);
        end else if (op !== ev[got] || op !== e) begin
          n_fail++; $display("FAIL edge%0d got=%0d exp=%0d", got, op, ev[got]);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 7) begin n_fail++; $display("FAIL edge_count got=%0d exp=7", got); end
  endtask

  task automatic test_stall();
    logic [7:0] held;
    logic [7:0] e;
    logic       v, r;
    held = 8'h00;
    for (int cyc = 0; cyc < 30; cyc++) begin
      v = (cyc < 14);
      r = !(cyc >= 3 && cyc < 8);
      step(v, gen_float(), r);
      if (cyc == 3) held = op;
      if (cyc >= 3 && cyc < 8) begin
        n_tests++;
        if (ir !== 1'b0 || ov !== 1'b1 || op !== held || fd !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_hold cyc=%0d got ir=%b ov=%b pix=%0d fd=%b exp ir=0 ov=1 pix=%0d fd=0",
                   cyc, ir, ov, op, fd, held);
        end
      end
      if (ot) begin
        n_tests++;
        $display("[TB] stall cyc=%0d pix=%0d", cyc, op);
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stall_extra got=%0d exp=none", op);
        end else begin
          e = exp_q.pop_front();
          if (op !== e) begin n_fail++; $display("FAIL stall_pix got=%0d exp=%0d", op, e); end
        end
      end
    end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_lost got=%0d pending exp=0", exp_q.size()); end
  endtask

  task automatic test_frame();
    int         sent, got;
    logic [7:0] e;
    sent = 0;
    got  = 0;
    do_reset();
    for (int cyc = 0; cyc < 300 && got < 9; cyc++) begin
      step(sent < 9, gen_float(), 1'($urandom_range(0, 1)));
      if (bus.in_valid && ir) sent++;
      if (ot) begin
        got++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        $display("[TB] frame pixel #%0d pix=%0d fd=%b cnt=%0d", got, op, fd, pc);
        n_tests++;
        if (op !== e || fd !== (got == 4 || got == 8)) begin
          n_fail++;
          $display("FAIL frame_pix%0d got pix=%0d fd=%b exp pix=%0d fd=%b", got, op, fd, e, (got == 4 || got == 8));
        end
      end else if (fd !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_done_idle got=%b exp=0", fd);
      end
    end
    n_tests++;
    if (got != 9 || bus.pixel_count !== 18'd1) begin
      n_fail++; $display("FAIL frame_end got count=%0d delivered=%0d exp count=1 delivered=9", bus.pixel_count, got);
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] w;
    logic [7:0]  e;
    int          got;
    do_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      step(cyc < 4, gen_float(), 1'b1);
      if (ot) begin
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        if (op !== e) begin n_fail++; $display("FAIL midrst_pre got=%0d exp=%0d", op, e); end
      end
    end
    n_tests++;
    if (bus.pixel_count !== 18'd2) begin n_fail++; $display("FAIL midrst_precount got=%0d exp=2", bus.pixel_count); end
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_xfer_in_reset got=%b exp=0", bus.out_valid); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.pixel_count !== 18'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_after got ov=%b cnt=%0d ir=%b exp ov=0 cnt=0 ir=1", bus.out_valid, bus.pixel_count, bus.in_ready);
    end
    w = 32'h42C80000;
    got = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      step(cyc == 0, w, 1'b1);
      if (ot) begin
        n_tests++;
        $display("[TB] post-reset cyc=%0d pix=%0d", cyc, op);
        if (cyc != 3 || op !== 8'd100 || got != 0) begin
          n_fail++; $display("FAIL midrst_out got pix=%0d@%0d exp pix=100@3", op, cyc);
        end
        got++;
      end
    end
    n_tests++;
    if (got != 1 || bus.pixel_count !== 18'd1) begin
      n_fail++; $display("FAIL midrst_count got delivered=%0d cnt=%0d exp 1 1", got, bus.pixel_count);
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int          sent, got, cyc;
    logic [31:0] cur;
    logic [7:0]  e;
    logic        v;
    sent = 0;
    got  = 0;
    cyc  = 0;
    cur  = gen_float();
    while ((sent < 10000 || exp_q.size() != 0) && cyc < 60000) begin
      v = (sent < 10000) && ($urandom_range(0, 3) != 0);
      step(v, cur, 1'($urandom_range(0, 3) != 0));
      if (v && ir) begin
        sent++;
        cur = gen_float();
      end
      if (ot) begin
        n_tests++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
        $display("[TB] rand #%0d pix=%0d exp=%0d cnt=%0d fd=%b", got, op, e, pc, fd);
        if (op !== e || pc !== epc || fd !== efd) begin
          n_fail++;
          $display("FAIL rand%0d got pix=%0d cnt=%0d fd=%b exp pix=%0d cnt=%0d fd=%b", got, op, pc, fd, e, epc, efd);
        end
        got++;
      end
      cyc++;
    end
    n_tests++;
    if (got != 10000) begin n_fail++; $display("FAIL rand_timeout got delivered=%0d exp=10000", got); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_directed();
    test_edges();
    test_stall();
    test_frame();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
